// File: rtl/taus_urng_array.sv
// NUM_CH parallel taus88 uniform generators with per-channel seed loading, run enable,
// valid/ready output and a transfer counter. Define TAUS_SEED_GUARD_EN to replace degenerate seed words.
module taus_urng_array #(
    parameter int          NUM_CH = 2,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] SEED0  = 32'h7fffeeee,
    parameter logic [31:0] SEED1  = 32'h7ddddddd,
    parameter logic [31:0] SEED2  = 32'h7dddeeee,
    localparam int         CH_W   = (NUM_CH > 32'sd1) ? $clog2(NUM_CH) : 32'sd1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 seed_wr,
    input  logic [CH_W-1:0]      seed_ch,
    input  logic [1:0]           seed_idx,
    input  logic [31:0]          seed_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*NUM_CH-1:0] out_data,
    output logic [CNT_W-1:0]     sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESEED = 2'd2
    } state_e;

    function automatic logic [31:0] default_seed(input int ch, input int k);
        logic [31:0] base;
        logic [31:0] mix;
        case (k)
            32'sd0:  base = SEED0;
            32'sd1:  base = SEED1;
            default: base = SEED2;
        endcase
        mix = 32'(ch) * 32'h9E3779B9;
        return base ^ mix;
    endfunction

    function automatic logic [31:0] step0(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 5'd13) ^ s) >> 5'd19;
        return ((s & 32'hfffffffe) << 5'd12) ^ b;
    endfunction

    function automatic logic [31:0] step1(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 5'd2) ^ s) >> 5'd25;
        return ((s & 32'hfffffff8) << 5'd4) ^ b;
    endfunction

    function automatic logic [31:0] step2(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 5'd3) ^ s) >> 5'd11;
        return ((s & 32'hfffffff0) << 5'd17) ^ b;
    endfunction

`ifdef TAUS_SEED_GUARD_EN
    // Words that would lock a component into its all-zero cycle fall back to the channel default.
    function automatic logic [31:0] guard_seed(input int ch, input int k, input logic [31:0] w);
        logic degen;
        case (k)
            32'sd0:  degen = (w < 32'd2);
            32'sd1:  degen = (w < 32'd8);
            32'sd2:  degen = (w < 32'd16);
            default: degen = 1'b0;
        endcase
        if (degen) begin
            return default_seed(ch, k);
        end else begin
            return w;
        end
    endfunction
`endif

    state_e               state_q, state_d;
    logic [31:0]          st_q    [NUM_CH][3];
    logic [31:0]          st_d    [NUM_CH][3];
    logic [31:0]          st_nx_s [NUM_CH][3];
    logic [32*NUM_CH-1:0] samp_s;
    logic [32*NUM_CH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 accept_s;
    logic                 do_write_s;
    logic                 do_advance_s;
    logic                 do_count_s;

    assign accept_s   = out_valid_q & out_ready;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign sample_cnt = cnt_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a seed strobe pre-empts every state.
    always_comb begin
        state_d = state_q;
        if (seed_wr) begin
            state_d = ST_RESEED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (accept_s && !en) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RESEED: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: datapath controls.
    always_comb begin
        do_write_s   = 1'b0;
        do_advance_s = 1'b0;
        do_count_s   = 1'b0;
        if (seed_wr) begin
            do_write_s = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    do_advance_s = en & (~out_valid_q | out_ready);
                    do_count_s   = accept_s;
                end
                ST_IDLE, ST_RESEED: begin
                    do_advance_s = 1'b0;
                    do_count_s   = 1'b0;
                end
                default: begin
                    do_advance_s = 1'b0;
                    do_count_s   = 1'b0;
                end
            endcase
        end
    end

    // One taus88 step per channel from the current state.
    always_comb begin
        samp_s = {(32*NUM_CH){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            st_nx_s[c][0] = step0(st_q[c][0]);
            st_nx_s[c][1] = step1(st_q[c][1]);
            st_nx_s[c][2] = step2(st_q[c][2]);
            samp_s[32*c +: 32] = st_nx_s[c][0] ^ st_nx_s[c][1] ^ st_nx_s[c][2];
        end
    end

    // Datapath next state; out-of-range channel or component 3 matches no slot and is dropped.
    always_comb begin
        st_d        = st_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (do_write_s) begin
            out_valid_d = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 3; k++) begin
                    if ((int'(seed_ch) == c) && (int'(seed_idx) == k)) begin
`ifdef TAUS_SEED_GUARD_EN
                        st_d[c][k] = guard_seed(c, k, seed_data);
`else
                        st_d[c][k] = seed_data;
`endif
                    end else begin
                        st_d[c][k] = st_q[c][k];
                    end
                end
            end
        end else begin
            if (do_count_s) begin
                cnt_d = cnt_q + CNT_W'(1'b1);
            end else begin
                cnt_d = cnt_q;
            end
            if (do_advance_s) begin
                st_d        = st_nx_s;
                out_data_d  = samp_s;
                out_valid_d = 1'b1;
            end else if (do_count_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // Generator state, output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 3; k++) begin
                    st_q[c][k] <= default_seed(c, k);
                end
            end
            out_data_q  <= {(32*NUM_CH){1'b0}};
            out_valid_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 3; k++) begin
                    st_q[c][k] <= st_d[c][k];
                end
            end
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_taus_urng_array.sv
// Directed bench for taus_urng_array: control table plus hand-written run, backpressure,
// reset, reseed, guard and counter-wrap sequences against a taus88 reference model.
module tb_taus_urng_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        seed_wr;
    logic [0:0]  seed_ch;
    logic [1:0]  seed_idx;
    logic [31:0] seed_data;
    logic        out_ready;
    logic        out_valid, out_valid4;
    logic [63:0] out_data, out_data4;
    logic [31:0] sample_cnt;
    logic [3:0]  sample_cnt4;

    always #5 clk = ~clk;

    taus_urng_array #(.NUM_CH(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .seed_wr(seed_wr), .seed_ch(seed_ch),
        .seed_idx(seed_idx), .seed_data(seed_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .sample_cnt(sample_cnt)
    );

    taus_urng_array #(.NUM_CH(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .seed_wr(seed_wr), .seed_ch(seed_ch),
        .seed_idx(seed_idx), .seed_data(seed_data), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .sample_cnt(sample_cnt4)
    );

    typedef struct {
        logic        en;
        logic        rdy;
        logic        wr;
        logic        ch;
        logic [1:0]  idx;
        logic        v;
        logic [31:0] cnt;
        logic        fresh;
    } vec_t;

    vec_t        vt [18];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_s [2][3];
    logic [63:0] last_data;
    logic [31:0] exp_cnt;
    logic        exp_v;

    function automatic logic [31:0] dflt(input int c, input int k);
        logic [31:0] base;
        logic [31:0] mul;
        if (k == 0) base = 32'h7FFFEEEE;
        else if (k == 1) base = 32'h7DDDDDDD;
        else base = 32'h7DDDEEEE;
        mul = 32'h9E3779B9 * 32'(c);
        return base ^ mul;
    endfunction

    task automatic model_init();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 3; k++)
                m_s[c][k] = dflt(c, k);
    endtask

    task automatic model_step(output logic [63:0] smp);
        logic [31:0] t, a, b, d;
        for (int c = 0; c < 2; c++) begin
            t = ((m_s[c][0] << 13) ^ m_s[c][0]) >> 19;
            a = ((m_s[c][0] & 32'hFFFFFFFE) << 12) ^ t;
            t = ((m_s[c][1] << 2) ^ m_s[c][1]) >> 25;
            b = ((m_s[c][1] & 32'hFFFFFFF8) << 4) ^ t;
            t = ((m_s[c][2] << 3) ^ m_s[c][2]) >> 11;
            d = ((m_s[c][2] & 32'hFFFFFFF0) << 17) ^ t;
            m_s[c][0] = a;
            m_s[c][1] = b;
            m_s[c][2] = d;
            smp[32*c +: 32] = a ^ b ^ d;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic fresh);
        logic [63:0] exp_d;
        if (fresh) begin
            model_step(exp_d);
            last_data = exp_d;
        end else begin
            exp_d = last_data;
        end
        chk({tag, ".valid"}, 64'(out_valid), 64'(exp_v));
        chk({tag, ".valid4"}, 64'(out_valid4), 64'(exp_v));
        chk({tag, ".cnt"}, 64'(sample_cnt), 64'(exp_cnt));
        chk({tag, ".cnt4"}, 64'(sample_cnt4), 64'(exp_cnt[3:0]));
        chk({tag, ".data"}, out_data, exp_d);
        chk({tag, ".data4"}, out_data4, exp_d);
    endtask

    task automatic do_reset(input string tag, input logic with_wr);
        rst       = 1'b1;
        seed_wr   = with_wr;
        seed_ch   = 1'b0;
        seed_idx  = 2'd0;
        seed_data = 32'h12345678;
        @(negedge clk);
        rst       = 1'b0;
        seed_wr   = 1'b0;
        exp_v     = 1'b0;
        exp_cnt   = 32'd0;
        last_data = 64'd0;
        model_init();
        check_outs(tag, 1'b0);
    endtask

    task automatic run_stream(input int n, input int lat, input string tag);
        for (int i = 0; i < n; i++) begin
            en        = 1'b1;
            out_ready = 1'b1;
            seed_wr   = 1'b0;
            if (exp_v) exp_cnt = exp_cnt + 32'd1;
            @(negedge clk);
            exp_v = (i >= lat);
            check_outs(tag, exp_v);
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            en        = 1'b1;
            out_ready = 1'b0;
            seed_wr   = 1'b0;
            @(negedge clk);
            check_outs("hold", 1'b0);
        end
    endtask

    task automatic seed_write(input int c, input int k, input logic [31:0] d);
        en        = 1'b1;
        out_ready = 1'b1;
        seed_wr   = 1'b1;
        seed_ch   = c[0:0];
        seed_idx  = k[1:0];
        seed_data = d;
        @(negedge clk);
        exp_v = 1'b0;
        if (k < 3) begin
`ifdef TAUS_SEED_GUARD_EN
            if ((k == 0 && d < 32'd2) || (k == 1 && d < 32'd8) || (k == 2 && d < 32'd16))
                m_s[c][k] = dflt(c, k);
            else
                m_s[c][k] = d;
`else
            m_s[c][k] = d;
`endif
        end
        check_outs("seed", 1'b0);
    endtask

    initial begin
        //         en    rdy   wr    ch    idx   v     cnt    fresh
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'd0, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'd1, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd1, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd1, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'd2, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd2, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd3, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd3, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd3, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'd3, 1'b1};
        vt[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'd3, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd3, 1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd3, 1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'd3, 1'b1};
        vt[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 32'd3, 1'b0};
        vt[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd3, 1'b0};

        rst = 1'b1; en = 1'b0; seed_wr = 1'b0; seed_ch = 1'b0;
        seed_idx = 2'd0; seed_data = 32'd0; out_ready = 1'b0;
        do_reset("reset", 1'b0);

        for (int i = 0; i < 18; i++) begin
            en        = vt[i].en;
            out_ready = vt[i].rdy;
            seed_wr   = vt[i].wr;
            seed_ch   = vt[i].ch;
            seed_idx  = vt[i].idx;
            seed_data = 32'h0BADF00D;
            @(negedge clk);
            exp_v   = vt[i].v;
            exp_cnt = vt[i].cnt;
            check_outs($sformatf("vec%0d", i), vt[i].fresh);
        end

        // Long free run from reset, with hand-computed first channel-0 sample.
        do_reset("reset_run", 1'b0);
        run_stream(2, 1, "run");
        chk("first_ch0", 64'(out_data[31:0]), 64'(32'hFEE14BD2));
        run_stream(999, 0, "run");
        chk("cnt_999", 64'(sample_cnt), 64'(32'd999));
        chk("cnt4_999", 64'(sample_cnt4), 64'(4'd7));

        hold(10);
        run_stream(5, 0, "resume");

        // Reset mid-run while a reseed is also strobed; restart replays the default stream.
        do_reset("reset_mid", 1'b1);
        run_stream(20, 1, "restart");

        // Both channels reloaded with channel 0 defaults must emit the same stream.
        for (int k = 0; k < 3; k++) seed_write(0, k, dflt(0, k));
        for (int k = 0; k < 3; k++) seed_write(1, k, dflt(0, k));
        run_stream(20, 2, "same");
        chk("ch1_eq_model_ch0", 64'(out_data[63:32]), 64'(m_s[0][0] ^ m_s[0][1] ^ m_s[0][2]));

        do_reset("reset_guard", 1'b0);
        seed_write(0, 0, 32'd0);
        run_stream(20, 2, "guard");

        do_reset("reset_wrap", 1'b0);
        run_stream(22, 1, "wrap");
        chk("wrap_cnt4", 64'(sample_cnt4), 64'(4'd4));
        chk("wrap_cnt", 64'(sample_cnt), 64'(32'd20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/taus_urng_array.md
Name: taus_urng_array

Overview:
- Parametrised multi-channel successor to the team's three-component Tausworthe (taus88) uniform generator.
- NUM_CH independent 32-bit streams, each with its own three 32-bit state words.
- Per-channel runtime seed loading, global run enable, valid/ready output handshake and a sample counter.
- Feeds downstream Box-Muller / Gaussian noise stages that consume NUM_CH uniforms per transfer.

Parameters:
- NUM_CH, 2, number of independent generator channels (1..16).
- CNT_W, 32, width of the sample counter.
- SEED0, 32'h7fffeeee, base seed for component 0.
- SEED1, 32'h7ddddddd, base seed for component 1.
- SEED2, 32'h7dddeeee, base seed for component 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; generation advances only while high.
- seed_wr  in  1  seed write strobe, one word per cycle.
- seed_ch  in  clog2(NUM_CH) (min 1)  target channel.
- seed_idx  in  2  target component 0..2; value 3 ignored.
- seed_data  in  32  seed word.
- out_valid  out  1  out_data holds a fresh sample set.
- out_ready  in  1  consumer accepts when high with out_valid.
- out_data  out  32*NUM_CH  channel c in bits [32c+31:32c].
- sample_cnt  out  CNT_W  accepted transfers, wraps modulo 2^CNT_W.

Behaviour:
- Per-channel step (all ops 32-bit, shifts logical):
  - b = ((s0<<13)^s0)>>19; s0' = ((s0&32'hfffffffe)<<12)^b
  - b = ((s1<<2)^s1)>>25; s1' = ((s1&32'hfffffff8)<<4)^b (uses own s1)
  - b = ((s2<<3)^s2)>>11; s2' = ((s2&32'hfffffff0)<<17)^b
  - sample = s0'^s1'^s2'
- Default seed for channel c, component k: SEEDk ^ (c * 32'h9E3779B9), truncated to 32 bits. Channel 0 gets SEEDk unchanged.
- Reset (rst=1 at edge):
  - All states take their default seeds.
  - out_valid=0, out_data=0, sample_cnt=0, FSM=IDLE.
  - Reset overrides every other input, including mid-run and mid-reseed.
- FSM:
  - IDLE: out_valid=0. Goes to RUN when en=1 and seed_wr=0.
  - RUN: advance = en & (!out_valid | out_ready). On advance, every channel steps once, out_data <= samples, out_valid <= 1.
    - Accept (out_valid & out_ready) with en=0: out_valid <= 0, go to IDLE.
    - Accept increments sample_cnt.
  - RESEED: entered from any state on seed_wr=1.
    - Writes state[seed_ch][seed_idx] <= seed_data.
    - Sets out_valid <= 0, discarding any pending sample (not counted).
    - Stays while seed_wr=1. On the first cycle with seed_wr=0, goes to IDLE.
- Latency:
  - First out_valid rises 1 cycle after the first RUN cycle with en=1.
  - With out_ready held high and en=1, one sample set per cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data and all states are frozen.
- seed_ch >= NUM_CH or seed_idx=3: write ignored, but still invalidates output.
- Simultaneous seed_wr and accept: seed_wr wins; no transfer is counted.
- sample_cnt wraps from all-ones to 0 with no flag.

Optional Feature:
- Macro TAUS_SEED_GUARD_EN.
- Defined: any seed word written with component 0 < 2, component 1 < 8 or component 2 < 16 is replaced by that channel's default seed for the component. This prevents degenerate all-zero streams.
- Not defined: seed words are stored verbatim and degenerate seeds are the user's responsibility.

Test Plan:
- Reset, en=1, out_ready=1, 1000 cycles, NUM_CH=2 -> out_data matches a bit-exact C taus88 model per channel. Channel 0 uses seeds 7fffeeee/7ddddddd/7dddeeee. sample_cnt=999 or 1000 per the latency rule.
- Hold out_ready=0 for 10 cycles mid-run -> out_data and sample_cnt stable. Resume -> next sample equals the model's next value, none skipped.
- Write channel 1 seeds 1/2/3, in that order, = channel 0 defaults, then run -> channel 1 output identical to channel 0 every cycle. out_valid drops during the writes.
- Guard defined: write 0 to channel 0 component 0 -> output identical to the post-reset default stream. Guard undefined: stream follows the model with s0=0.
- Assert rst during RUN with out_valid=1 -> next cycle out_valid=0, sample_cnt=0; restart reproduces the first-run sequence exactly.
- CNT_W=4, 20 accepts -> sample_cnt reads 4 after wrap.
